// File: rtl/dense_2d_serializer.sv
// Serializes NUM_TREES 32-bit tree results per vector into requantized 8-bit pixels.
// Optional macro OUT_RELU_EN clamps negative shifted values to zero before saturation.
module dense_2d_serializer #(
    parameter int NUM_TREES  = 2,
    parameter int SHIFT      = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [32*NUM_TREES-1:0]   vec_in,
    input  logic                      vec_valid,
    output logic                      vec_ready,
    output logic [7:0]                pixel_out,
    output logic                      pixel_valid,
    input  logic                      pixel_ready,
    output logic                      sat_flag,
    output logic                      busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = (NUM_TREES > 1) ? $clog2(NUM_TREES) : 1;
    localparam logic [TW-1:0] LAST_IDX = TW'(NUM_TREES - 1);

    // Returns {saturated, pixel}.
    function automatic logic [8:0] requant(input logic signed [31:0] val);
        logic signed [31:0] v;
        v = val >>> SHIFT;
`ifdef OUT_RELU_EN
        if (v < 0) v = '0;
`endif
        if (v > 32'sd127)       return {1'b1, 8'h7F};
        else if (v < -32'sd128) return {1'b1, 8'h80};
        else                    return {1'b0, v[7:0]};
    endfunction

    logic [32*NUM_TREES-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]             wr_ptr_q, rd_ptr_q, count;
    logic [TW-1:0]           idx_q, idx_d, src_idx;
    logic [7:0]              pixel_out_q, pix_d;
    logic                    pixel_valid_q, sat_pix_q, sat_flag_q, sat_d;
    logic                    empty, full, hs, last, pop, push, load, nv;
    logic [AW-1:0]           rd_addr, rd_addr_nxt;
    logic [32*NUM_TREES-1:0] src_vec;
    logic signed [31:0]      tree_val;

    assign count       = wr_ptr_q - rd_ptr_q;
    assign empty       = (wr_ptr_q == rd_ptr_q);
    assign full        = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_addr     = rd_ptr_q[AW-1:0];
    assign rd_addr_nxt = rd_addr + AW'(1);
    assign hs          = pixel_valid_q & pixel_ready;
    assign last        = (idx_q == LAST_IDX);
    assign pop         = hs & last;
    assign push        = vec_valid & ~full;

    assign vec_ready   = ~full;
    assign pixel_out   = pixel_out_q;
    assign pixel_valid = pixel_valid_q;
    assign sat_flag    = sat_flag_q;
    assign busy        = ~empty | pixel_valid_q;

    // The output register always holds tree idx_q of the FIFO head; on the last
    // tree's handshake it reloads straight from the next entry so vectors stream gap-free.
    always_comb begin
        idx_d   = idx_q;
        load    = 1'b0;
        nv      = 1'b0;
        src_vec = mem_q[rd_addr];
        src_idx = idx_q;
        if (hs) begin
            load = 1'b1;
            if (last) begin
                idx_d   = '0;
                src_vec = mem_q[rd_addr_nxt];
                src_idx = '0;
                nv      = (count > (AW+1)'(1));
            end else begin
                idx_d   = idx_q + TW'(1);
                src_idx = idx_d;
                nv      = 1'b1;
            end
        end else if (!pixel_valid_q) begin
            load = 1'b1;
            nv   = ~empty;
        end
        tree_val       = src_vec[int'(src_idx)*32 +: 32];
        {sat_d, pix_d} = requant(tree_val);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            idx_q         <= '0;
            pixel_out_q   <= '0;
            pixel_valid_q <= 1'b0;
            sat_pix_q     <= 1'b0;
            sat_flag_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            idx_q <= idx_d;
            if (load) begin
                pixel_valid_q <= nv;
                pixel_out_q   <= nv ? pix_d : 8'h00;
                sat_pix_q     <= sat_d & nv;
            end
            if (hs && sat_pix_q) sat_flag_q <= 1'b1;
        end
    end

    // Storage needs no reset: pointers alone define which entries are live.
    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= vec_in;
    end

endmodule

// File: tb/tb_dense_2d_serializer.sv
// Directed bench: three instances (SHIFT=0, 2, 1) share stimulus and are checked with immediate assertions.
module tb_dense_2d_serializer;

    logic        clock = 1'b0;
    logic        reset;
    logic [63:0] vec_in;
    logic        vec_valid;
    logic        pixel_ready;
    logic        vec_ready [3];
    logic [7:0]  po [3];
    logic        pv [3];
    logic        sat [3];
    logic        busy [3];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    dense_2d_serializer #(.NUM_TREES(2), .SHIFT(0), .FIFO_DEPTH(4)) u0 (
        .clock(clock), .reset(reset), .vec_in(vec_in), .vec_valid(vec_valid),
        .vec_ready(vec_ready[0]), .pixel_out(po[0]), .pixel_valid(pv[0]),
        .pixel_ready(pixel_ready), .sat_flag(sat[0]), .busy(busy[0]));
    dense_2d_serializer #(.NUM_TREES(2), .SHIFT(2), .FIFO_DEPTH(4)) u1 (
        .clock(clock), .reset(reset), .vec_in(vec_in), .vec_valid(vec_valid),
        .vec_ready(vec_ready[1]), .pixel_out(po[1]), .pixel_valid(pv[1]),
        .pixel_ready(pixel_ready), .sat_flag(sat[1]), .busy(busy[1]));
    dense_2d_serializer #(.NUM_TREES(2), .SHIFT(1), .FIFO_DEPTH(4)) u2 (
        .clock(clock), .reset(reset), .vec_in(vec_in), .vec_valid(vec_valid),
        .vec_ready(vec_ready[2]), .pixel_out(po[2]), .pixel_valid(pv[2]),
        .pixel_ready(pixel_ready), .sat_flag(sat[2]), .busy(busy[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    logic [7:0] e_neg0, e_neg1, e_neg2;

    initial begin
`ifdef OUT_RELU_EN
        e_neg0 = 8'h00; e_neg1 = 8'h00; e_neg2 = 8'h00;
`else
        e_neg0 = 8'hFB; e_neg1 = 8'hFE; e_neg2 = 8'hFD;
`endif
        reset = 1'b0; vec_in = '0; vec_valid = 1'b0; pixel_ready = 1'b0;
        #1;
        chk("rst_pv", pv[0], 0);
        chk("rst_po", po[0], 0);
        chk("rst_vr", vec_ready[0], 1);
        chk("rst_busy", busy[0], 0);
        chk("rst_sat", sat[0], 0);
        tick(); tick();
        reset = 1'b1;
        tick();

        // Vector {20, 180}: saturation at SHIFT=0, scaled at SHIFT=2 and 1
        pixel_ready = 1'b1;
        vec_in = {32'd20, 32'd180}; vec_valid = 1'b1;
        tick();
        vec_valid = 1'b0;
        chk("lat_pv", pv[0], 0);
        chk("lat_busy", busy[0], 1);
        tick();
        chk("t0_pv", pv[0], 1);
        chk("t0_s0", po[0], 8'h7F);
        chk("t0_s2", po[1], 8'h2D);
        chk("t0_s1", po[2], 8'h5A);
        chk("t0_sat_pre", sat[0], 0);
        tick();
        chk("t1_pv", pv[0], 1);
        chk("t1_s0", po[0], 8'h14);
        chk("t1_s2", po[1], 8'h05);
        chk("t1_s1", po[2], 8'h0A);
        chk("sat_s0", sat[0], 1);
        tick();
        chk("end_pv", pv[0], 0);
        chk("end_busy", busy[0], 0);
        chk("sat_s2", sat[1], 0);
        chk("sat_s1", sat[2], 0);
        chk("sat_sticky", sat[0], 1);

        // Negative value: floor shift, optional ReLU
        vec_in = {32'd0, 32'hFFFF_FFFB}; vec_valid = 1'b1;
        tick();
        vec_valid = 1'b0;
        tick();
        chk("neg_s0", po[0], e_neg0);
        chk("neg_s2", po[1], e_neg1);
        chk("neg_s1", po[2], e_neg2);
        tick();
        chk("neg_t1", po[2], 8'h00);
        chk("neg_sat", sat[2], 0);
        tick();
        chk("neg_end", pv[2], 0);

        // Backpressure mid-vector
        pixel_ready = 1'b0;
        vec_in = {32'd33, 32'd11}; vec_valid = 1'b1;
        tick();
        vec_valid = 1'b0;
        tick();
        chk("bp_t0", po[0], 8'd11);
        pixel_ready = 1'b1;
        tick();
        chk("bp_t1", po[0], 8'd33);
        pixel_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_po", po[0], 8'd33);
            chk("bp_hold_pv", pv[0], 1);
        end
        pixel_ready = 1'b1;
        tick();
        chk("bp_done", pv[0], 0);

        // Fill FIFO with A..D while stalled
        pixel_ready = 1'b0;
        vec_valid = 1'b1;
        vec_in = {32'd2, 32'd1}; tick(); chk("fill1_vr", vec_ready[0], 1);
        vec_in = {32'd4, 32'd3}; tick(); chk("fill2_vr", vec_ready[0], 1);
        vec_in = {32'd6, 32'd5}; tick(); chk("fill3_vr", vec_ready[0], 1);
        vec_in = {32'd8, 32'd7}; tick(); chk("fill4_vr", vec_ready[0], 0);
        chk("fill_po", po[0], 8'd1);
        vec_in = {32'd10, 32'd9};
        pixel_ready = 1'b1;
        tick();
        chk("full_hs_vr", vec_ready[0], 0);
        chk("full_a1", po[0], 8'd2);
        tick();
        chk("pop_vr", vec_ready[0], 1);
        chk("pop_b0", po[0], 8'd3);
        vec_valid = 1'b0;
        tick();
        chk("b1", po[0], 8'd4);

        // Reset mid-burst
        reset = 1'b0;
        #1;
        chk("mrst_pv", pv[0], 0);
        chk("mrst_po", po[0], 0);
        chk("mrst_sat", sat[0], 0);
        chk("mrst_busy", busy[0], 0);
        chk("mrst_vr", vec_ready[0], 1);
        tick();
        reset = 1'b1;
        tick();
        chk("post_idle", pv[0], 0);
        vec_in = {32'd7, 32'd9}; vec_valid = 1'b1;
        tick();
        vec_valid = 1'b0;
        tick();
        chk("post_t0", po[0], 8'h09);
        chk("post_t0_pv", pv[0], 1);
        tick();
        chk("post_t1", po[0], 8'h07);
        tick();
        chk("post_end", pv[0], 0);
        tick();
        chk("post_quiet", pv[0], 0);
        chk("post_busy", busy[0], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dense_2d_serializer.md
DENSE_2D_SERIALIZER -- requirements
Module: dense_2d_serializer

Interface
REQ-001 SHALL have parameter NUM_TREES, default 2: number of parallel 32-bit tree results per input vector.
REQ-002 SHALL have parameter SHIFT, default 0: arithmetic right-shift applied before requantization, range 0..31.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: input vector FIFO entries, power of two, at least 2.
REQ-004 SHALL have port clock  input  1  clock; all logic rising-edge.
REQ-005 SHALL have port reset  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port vec_in  input  32*NUM_TREES  tree results, two's complement; tree k at bits [32k+31:32k].
REQ-007 SHALL have port vec_valid  input  1  vec_in valid.
REQ-008 SHALL have port vec_ready  output  1  FIFO can accept a vector.
REQ-009 SHALL have port pixel_out  output  8  requantized signed pixel.
REQ-010 SHALL have port pixel_valid  output  1  pixel_out valid.
REQ-011 SHALL have port pixel_ready  input  1  downstream accepts pixel.
REQ-012 SHALL have port sat_flag  output  1  sticky saturation indicator.
REQ-013 SHALL have port busy  output  1  FIFO non-empty or pixel pending.

Function
REQ-014 SHALL accept a vector on a rising edge where vec_valid and vec_ready are both 1; vec_ready SHALL equal "FIFO not full", independent of same-cycle pops.
REQ-015 SHALL emit the trees of each vector in order tree 0 to tree NUM_TREES-1, one pixel per handshake, where a handshake is pixel_valid and pixel_ready both 1.
REQ-016 SHALL use a tree-index counter that increments on each handshake; on the handshake of tree NUM_TREES-1 the counter SHALL wrap to 0 and the FIFO head SHALL pop.
REQ-017 Latency: with the FIFO empty, a vector accepted at edge N SHALL present tree 0 with pixel_valid=1 after edge N+1.
REQ-018 Back-to-back vectors SHALL stream with no bubble across vector boundaries while pixel_ready=1.
REQ-019 While pixel_valid=1 and pixel_ready=0, pixel_out and pixel_valid SHALL hold stable.
REQ-020 Requantization: v = value >>> SHIFT (arithmetic, floor); v>127 -> 127, v<-128 -> -128, else v[7:0].
REQ-021 sat_flag SHALL set on the handshake of any saturated pixel and SHALL clear only on reset.
REQ-022 FIFO full with simultaneous pop: vec_ready stays 0 that cycle; no push occurs.
REQ-023 busy SHALL be 0 only when the FIFO is empty and pixel_valid=0.

Reset
REQ-024 Reset asserted SHALL immediately clear the FIFO pointers and tree counter, and drive pixel_out=0, pixel_valid=0, sat_flag=0, busy=0, vec_ready=1.
REQ-025 Reset asserted mid-vector SHALL discard all partially emitted and queued vectors; the first pixel after release SHALL come from a vector accepted after release.

Configuration
REQ-026 Macro OUT_RELU_EN defined: after the shift, negative v SHALL become 0 before saturation, so pixel_out is in 0..127 and negative values never set sat_flag.
REQ-027 OUT_RELU_EN undefined: signed requantization per REQ-020 with no clamp.

Verification
REQ-028 SHIFT=0, pixel_ready=1, one vector {tree1=20, tree0=180} -> pixels 0x7F then 0x14 on consecutive cycles; sat_flag=1 after the first handshake.
REQ-029 SHIFT=2, same vector -> pixels 0x2D (45) then 0x05; sat_flag stays 0.
REQ-030 SHIFT=1, tree0=0xFFFFFFFB (-5) -> pixel 0xFD (-3); with OUT_RELU_EN -> 0x00.
REQ-031 pixel_ready=0 for 3 cycles mid-vector -> pixel_out and pixel_valid unchanged for those cycles; next handshake yields the next tree, with no pixel lost or duplicated.
REQ-032 pixel_ready=0, push vectors continuously -> vec_ready=0 after the FIFO_DEPTH-th (4th) accept; one vector's worth of handshakes (2) -> vec_ready=1 the next cycle.
REQ-033 Reset asserted after tree 0 of a 2-vector burst -> outputs cleared immediately; a new vector {7,9} after release -> pixels 0x09 then 0x07 only.
